// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display path: blanking codes, scan FSM
// encoding and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Entry n is the glyph for nibble n; b and d are lowercase.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex_dec
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_GLYPHS[nibble];
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with per-slot blanking, leading-zero
// suppression and a LOAD/LOAD_ACK handshake that commits values on frame edges.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [15:0] DATA_IN,
  input  logic        LOAD,
  input  logic        LZ_EN,
  output logic        LOAD_ACK,
  output logic        FRAME,
  output logic [3:0]  DIG,
  output logic [6:0]  SEG
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic             ack_q, ack_d;
  logic             frame_q, frame_d;

  logic       wrap;
  logic       boundary;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic [3:0] lead_zero;

  assign wrap     = (cnt_q == CNT_MAX);
  assign boundary = wrap && (idx_q == 2'd3);
  assign nibble   = active_q[{idx_q, 2'b00} +: 4];

  // Digit gi is a leading zero when it and every digit above it are zero.
  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lead_zero[gi] = (active_q[15:4*gi] == '0);
    end
  endgenerate

  seg7_hex_dec u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    idx_d        = wrap ? idx_q + 2'd1 : idx_q;
    state_d      = state_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    dig_d        = DIG_OFF;
    seg_d        = SEG_OFF;
    ack_d        = 1'b0;
    frame_d      = boundary;

    // State tracks cnt so it always matches cnt_q in the same cycle.
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (wrap)                state_d = ST_BLANK;
      default:                           state_d = ST_BLANK;
    endcase

    if (state_q == ST_SHOW) begin
      dig_d = ~(4'b0001 << idx_q);
      seg_d = (LZ_EN && lead_zero[idx_q]) ? SEG_OFF : glyph;
    end

    // A load landing on the boundary itself bypasses pending.
    if (boundary) begin
      if (LOAD)              active_d = DATA_IN;
      else if (pend_valid_q) active_d = pending_q;
      ack_d        = LOAD || pend_valid_q;
      pend_valid_d = 1'b0;
    end else if (LOAD) begin
      pending_d    = DATA_IN;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_valid_q <= 1'b0;
      dig_q        <= DIG_OFF;
      seg_q        <= SEG_OFF;
      ack_q        <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
      ack_q        <= ack_d;
      frame_q      <= frame_d;
    end
  end

  assign DIG      = dig_q;
  assign SEG      = seg_q;
  assign LOAD_ACK = ack_q;
  assign FRAME    = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2: each
// committed value is checked cycle by cycle over one full 32-cycle frame.
module tb_display_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] DATA_IN;
  logic        LOAD;
  logic        LZ_EN;
  logic        LOAD_ACK;
  logic        FRAME;
  logic [3:0]  DIG;
  logic [6:0]  SEG;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]     data;
    logic            lz;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t vecs [20];

  logic [6:0] glyph_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLOCK_50 (clk),
    .RESET    (RESET),
    .DATA_IN  (DATA_IN),
    .LOAD     (LOAD),
    .LZ_EN    (LZ_EN),
    .LOAD_ACK (LOAD_ACK),
    .FRAME    (FRAME),
    .DIG      (DIG),
    .SEG      (SEG)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual{ack,frame,dig,seg}=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_off(input string name);
    check(name, {LOAD_ACK, FRAME, DIG, SEG}, {1'b0, 1'b0, 4'hF, 7'h7F});
  endtask

  // Called on a negedge where the slot counter is 0 on digit 0.
  task automatic check_frame(input logic [3:0][6:0] exp_seg, input string name);
    int d;
    int c;
    logic [3:0] edig;
    logic [6:0] eseg;
    for (int k = 0; k < 4 * SD; k++) begin
      @(negedge clk);
      d = k / SD;
      c = k % SD;
      if (c < BC) begin
        edig = 4'hF;
        eseg = 7'h7F;
      end else begin
        edig = ~(4'b0001 << d);
        eseg = exp_seg[d];
      end
      check($sformatf("%s k=%0d", name, k), {LOAD_ACK, FRAME, DIG, SEG},
            {1'b0, (k == 4 * SD - 1), edig, eseg});
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    DATA_IN = v;
    LOAD    = 1'b1;
    @(negedge clk);
    LOAD    = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int  n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < 5 * SD && !got) begin
      @(negedge clk);
      n++;
      if (LOAD_ACK === 1'b1) got = 1'b1;
    end
    check({name, " ack_seen"}, {12'd0, got}, 13'd1);
    check({name, " frame_with_ack"}, {12'd0, FRAME}, 13'd1);
  endtask

  task automatic set_vec(input int i, input logic [15:0] data, input logic lz,
                         input logic [3:0][6:0] exp);
    vecs[i].data = data;
    vecs[i].lz   = lz;
    vecs[i].exp  = exp;
  endtask

  initial begin
    RESET   = 1'b1;
    LOAD    = 1'b0;
    DATA_IN = 16'h0000;
    LZ_EN   = 1'b0;

    set_vec(0, 16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19});
    set_vec(1, 16'h0070, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40});
    set_vec(2, 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    set_vec(3, 16'h0070, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40});
    for (int n = 0; n < 16; n++)
      set_vec(4 + n, 16'(n), 1'b1, {7'h7F, 7'h7F, 7'h7F, glyph_ref[n]});

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_off("reset_state");
    end
    RESET = 1'b0;
    check_frame({4{7'h40}}, "post_reset");
    $display("post_reset frame checked");

    for (int i = 0; i < 20; i++) begin
      LZ_EN = vecs[i].lz;
      repeat (5) @(negedge clk);
      pulse_load(vecs[i].data);
      wait_ack($sformatf("vec%0d", i));
      check_frame(vecs[i].exp, $sformatf("vec%0d", i));
      $display("vec %0d data=%h lz=%0d checked", i, vecs[i].data, vecs[i].lz);
    end

    // Two loads in one frame: latest wins, one ACK.
    LZ_EN = 1'b0;
    repeat (3) @(negedge clk);
    pulse_load(16'hAAAA);
    repeat (3) @(negedge clk);
    pulse_load(16'h5555);
    wait_ack("double_load");
    check_frame({4{7'h12}}, "double_load");
    $display("double_load AAAA then 5555 checked");

    // Load exactly on the boundary cycle.
    for (int k = 0; k < 4 * SD - 1; k++) begin
      @(negedge clk);
      check($sformatf("pre_boundary k=%0d", k), {12'd0, LOAD_ACK}, 13'd0);
    end
    DATA_IN = 16'hFFFF;
    LOAD    = 1'b1;
    @(negedge clk);
    LOAD    = 1'b0;
    check("boundary_load ack+frame", {11'd0, LOAD_ACK, FRAME}, 13'b11);
    check_frame({4{7'h0E}}, "boundary_load");
    $display("boundary_load FFFF checked");

    // Reset while a load is pending: discarded, no ACK, display restarts.
    repeat (4) @(negedge clk);
    pulse_load(16'h9999);
    repeat (3) @(negedge clk);
    RESET = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_off("reset_pending");
    end
    RESET = 1'b0;
    check_frame({4{7'h40}}, "after_reset_pending");
    $display("reset_with_pending checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
